// File: rtl/vnu_serial_pkg.sv
// Shared LDPC definitions: default message width, sum sizing, symmetric saturation, VNU states.
package ldpc_pkg;

    localparam int MSG_W_DEF = 8;

    typedef enum logic {ACC, EMIT} vnu_state_t;

    typedef struct packed {
        logic signed [31:0] value;
        logic               sat;
    } sat_res_t;

    function automatic int sum_w(input int msg_w, input int deg);
        return msg_w + $clog2(deg + 1);
    endfunction

    // Clamp to +/-(2^(msg_w-1)-1) so the most negative code is never produced.
    function automatic sat_res_t sat_sym(input logic signed [31:0] value, input int msg_w);
        sat_res_t         r;
        logic signed [31:0] lim;
        lim     = (32'sd1 <<< (msg_w - 1)) - 32'sd1;
        r.sat   = 1'b1;
        r.value = value;
        if (value > lim)
            r.value = lim;
        else if (value < -lim)
            r.value = -lim;
        else
            r.sat = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/vnu_serial_if.sv
// Serial VNU handshake bundle: input beats (intrinsic + message) and extrinsic output beats.
interface vnu_serial_if #(
    parameter int MSG_W = 8,
    parameter int DEG   = 3,
    parameter int CNT_W = (DEG > 1) ? $clog2(DEG) : 1
);
    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] in_intr;
    logic [MSG_W-1:0] in_msg;
    logic             out_valid;
    logic             out_ready;
    logic [MSG_W-1:0] out_msg;
    logic [CNT_W-1:0] out_idx;
    logic             out_hard;
    logic             out_last;

    modport master (
        output in_valid, in_intr, in_msg, out_ready,
        input  in_ready, out_valid, out_msg, out_idx, out_hard, out_last
    );

    modport slave (
        input  in_valid, in_intr, in_msg, out_ready,
        output in_ready, out_valid, out_msg, out_idx, out_hard, out_last
    );
endinterface

// File: rtl/vnu_serial_sat.sv
// Combinational signed IN_W-to-OUT_W symmetric saturator with an out-of-range flag.
module vnu_sat
    import ldpc_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    sat_res_t res;
    logic     unused_hi;

    always_comb begin
        res = sat_sym(32'(din), OUT_W);
    end

    assign dout      = res.value[OUT_W-1:0];
    assign sat       = res.sat;
    assign unused_hi = ^res.value[31:OUT_W];
endmodule

// File: rtl/vnu_serial.sv
// Sequential min-sum variable node: accumulates intrinsic + DEG messages, then emits DEG extrinsics.
// Optional saturation counter port enabled by VNU_SAT_CNT_EN.
module vnu_serial
    import ldpc_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int DEG   = 3,
    parameter int CNT_W = (DEG > 1) ? $clog2(DEG) : 1
) (
    input  logic        clk,
    input  logic        rst,
    vnu_serial_if.slave bus
`ifdef VNU_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int               SUM_W = sum_w(MSG_W, DEG);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEG - 1);

    vnu_state_t              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic signed [SUM_W-1:0] acc, acc_n, diff;
    logic [MSG_W-1:0]        buffer [DEG];
    logic [MSG_W-1:0]        msg_q;
    logic signed [MSG_W-1:0] sat_msg;
    logic [CNT_W-1:0]        idx_q;
    logic                    hard_q, last_q, load_out, diff_sat;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        unique case (state)
            ACC: if (bus.in_valid) begin
                acc_n = ((cnt == '0) ? SUM_W'($signed(bus.in_intr)) : acc)
                        + SUM_W'($signed(bus.in_msg));
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = EMIT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            EMIT: if (bus.out_ready) begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ACC;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: ;
        endcase
        // Output regs preload the beat that will be visible next cycle; buffer[0] is
        // already stored when the final input beat arrives since DEG >= 2.
        load_out = (state_n == EMIT) && ((state == ACC) || bus.out_ready);
        diff     = acc_n - SUM_W'($signed(buffer[cnt_n]));
    end

    vnu_sat #(.IN_W(SUM_W), .OUT_W(MSG_W)) u_sat (
        .din  (diff),
        .dout (sat_msg),
        .sat  (diff_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ACC;
            cnt    <= '0;
            acc    <= '0;
            msg_q  <= '0;
            idx_q  <= '0;
            hard_q <= 1'b0;
            last_q <= 1'b0;
            for (int unsigned i = 0; i < DEG; i++) buffer[i] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
            if (state == ACC && bus.in_valid) buffer[cnt] <= bus.in_msg;
            if (load_out) begin
                msg_q  <= sat_msg;
                idx_q  <= cnt_n;
                hard_q <= !acc_n[SUM_W-1] && (acc_n != '0);
                last_q <= (cnt_n == LAST);
            end
        end
    end

`ifdef VNU_SAT_CNT_EN
    logic sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q     <= 1'b0;
            sat_count <= '0;
        end else begin
            if (load_out) sat_q <= diff_sat;
            if (state == EMIT && bus.out_ready && sat_q && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = diff_sat;
`endif

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_msg   = msg_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_hard  = hard_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_vnu_serial.sv
// Directed table-driven bench for vnu_serial (MSG_W=8, DEG=3), plus stall, bubble and reset sequences.
module tb_vnu_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_sat = 0;

    vnu_serial_if #(.MSG_W(8), .DEG(3)) bus ();

`ifdef VNU_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    vnu_serial #(.MSG_W(8), .DEG(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef VNU_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] intr;
        logic signed [7:0] m [3];
        logic signed [7:0] e [3];
        logic              hard;
        int                sat_n;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(int intr, int m0, int m1, int m2,
                                int e0, int e1, int e2, int hard, int sat_n);
        vec_t v;
        v.intr  = 8'(intr);
        v.m[0]  = 8'(m0);
        v.m[1]  = 8'(m1);
        v.m[2]  = 8'(m2);
        v.e[0]  = 8'(e0);
        v.e[1]  = 8'(e1);
        v.e[2]  = 8'(e2);
        v.hard  = 1'(hard);
        v.sat_n = sat_n;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit bubbles);
        for (int b = 0; b < 3; b++) begin
            bus.in_valid = 1'b1;
            bus.in_intr  = (b == 0) ? v.intr : 8'($urandom);
            bus.in_msg   = v.m[b];
            check("in_ready_acc", int'(bus.in_ready), 1);
            tick();
            if (bubbles && b < 2) begin
                bus.in_valid = 1'b0;
                bus.in_intr  = 8'($urandom);
                bus.in_msg   = 8'($urandom);
                tick();
                tick();
                check("out_valid_bubble", int'(bus.out_valid), 0);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_beat(input vec_t v, input int k);
        check("out_valid", int'(bus.out_valid), 1);
        check("out_msg", int'($signed(bus.out_msg)), int'(v.e[k]));
        check("out_idx", int'(bus.out_idx), k);
        check("out_last", int'(bus.out_last), (k == 2) ? 1 : 0);
        check("out_hard", int'(bus.out_hard), int'(v.hard));
        check("in_ready_emit", int'(bus.in_ready), 0);
    endtask

    task automatic collect(input vec_t v, input int stall_beat);
        for (int k = 0; k < 3; k++) begin
            check_beat(v, k);
            if (k == stall_beat) begin
                bus.out_ready = 1'b0;
                repeat (4) begin
                    tick();
                    check_beat(v, k);
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
        check("out_valid_done", int'(bus.out_valid), 0);
        check("in_ready_done", int'(bus.in_ready), 1);
        exp_sat += v.sat_n;
`ifdef VNU_SAT_CNT_EN
        check("sat_count", int'(sat_count), exp_sat);
`endif
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_msg", int'(bus.out_msg), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_out_hard", int'(bus.out_hard), 0);
        check("rst_out_last", int'(bus.out_last), 0);
`ifdef VNU_SAT_CNT_EN
        check("rst_sat_count", int'(sat_count), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(  10,    5,   -3,    2,    9,   17,   12, 1, 0);
        vecs[1] = mk(  -4,    1,    2,    1,   -1,   -2,   -1, 0, 0);
        vecs[2] = mk( 127,  127,  127,  127,  127,  127,  127, 1, 3);
        vecs[3] = mk(-128, -128, -128, -128, -127, -127, -127, 0, 3);
        vecs[4] = mk(   0,  100, -100,   50,  -50,  127,    0, 1, 1);
        vecs[5] = mk(  -1,    0,    0,    0,   -1,   -1,   -1, 0, 0);

        bus.in_valid  = 1'b0;
        bus.in_intr   = '0;
        bus.in_msg    = '0;
        bus.out_ready = 1'b1;
        #2;
        check_reset_outputs();
        #10 rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            send(vecs[i], 1'b0);
            collect(vecs[i], -1);
        end

        send(vecs[0], 1'b1);
        collect(vecs[0], 1);
        send(vecs[3], 1'b1);
        collect(vecs[3], 0);

        // Asynchronous reset in the middle of emission, with beat 1 on the bus.
        send(vecs[4], 1'b0);
        check_beat(vecs[4], 0);
        tick();
        check("pre_rst_idx", int'(bus.out_idx), 1);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs();
        #1 rst = 1'b0;
        exp_sat = 0;
        tick();
        send(vecs[0], 1'b0);
        collect(vecs[0], -1);
        send(vecs[1], 1'b0);
        collect(vecs[1], -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
